// File: rtl/tone_pkg.sv
// Shared types and the note-to-period lookup for the buzzer tone generator.
// Note indices 1..48 map to C3..B6; anything else is a rest (period 0).
package tone_pkg;

    localparam int NOTE_REST = 0;
    localparam int NOTE_MAX  = 48;
    localparam int PERIOD_W  = 20;

    typedef enum logic [1:0] {
        IDLE,
        GAP,
        PLAY,
        REST
    } state_t;

    // Octave-3 frequencies in milli-Hz; higher octaves are left shifts.
    function automatic logic [PERIOD_W-1:0] note_period(
        input int     idx,
        input longint clk_hz
    );
        longint f;
        if (idx <= NOTE_REST || idx > NOTE_MAX)
            return '0;
        case ((idx - 1) % 12)
            0:       f = 130813;
            1:       f = 138591;
            2:       f = 146832;
            3:       f = 155563;
            4:       f = 164814;
            5:       f = 174614;
            6:       f = 184997;
            7:       f = 195998;
            8:       f = 207652;
            9:       f = 220000;
            10:      f = 233082;
            default: f = 246942;
        endcase
        f = f << ((idx - 1) / 12);
        return PERIOD_W'((clk_hz * 1000) / f);
    endfunction

endpackage

// File: rtl/tone_pwm_core.sv
// Phase counter with wrap and duty compare; the high length is captured
// at phase 0 so duty changes only land on a period boundary.
module tone_pwm_core
    import tone_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [PERIOD_W-1:0] i_period,
    input  logic [PERIOD_W-1:0] i_high_len,
    input  logic                i_run,
    input  logic                i_clear,
    output logic                o_audio
);

    logic [PERIOD_W-1:0] r_phase;
    logic [PERIOD_W-1:0] r_high_len;
    logic                w_first;
    logic [PERIOD_W-1:0] w_hl;

    assign w_first = (r_phase == '0);
    assign w_hl    = w_first ? i_high_len : r_high_len;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase    <= '0;
            r_high_len <= '0;
            o_audio    <= 1'b0;
        end else if (i_clear || !i_run) begin
            r_phase <= '0;
            o_audio <= 1'b0;
        end else begin
            o_audio <= (r_phase < w_hl);
            if (w_first)
                r_high_len <= i_high_len;
            if (r_phase >= i_period - PERIOD_W'(1))
                r_phase <= '0;
            else
                r_phase <= r_phase + PERIOD_W'(1);
        end
    end

endmodule

// File: rtl/tone_gen.sv
// Beat-driven square-wave buzzer with volume duty and re-strike gap.
// Define TONE_GEN_FADE_EN for the per-note volume fade-out.
module tone_gen
    import tone_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int NOTE_W   = 6,
    parameter int VOL_W    = 3,
`ifdef TONE_GEN_FADE_EN
    parameter int GAP_CYC  = 1_000_000,
    parameter int FADE_CYC = 5_000_000
`else
    parameter int GAP_CYC  = 1_000_000
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              beat_tick,
    input  logic [NOTE_W-1:0] note,
    input  logic              strike,
    input  logic [VOL_W-1:0]  volume,
    output logic              audio_out,
    output logic              active,
    output logic [NOTE_W-1:0] note_q
);

    logic [PERIOD_W-1:0] w_ptab [2**NOTE_W];

    for (genvar g = 0; g < 2**NOTE_W; g++) begin : g_ptab
        assign w_ptab[g] = note_period(g, longint'(CLK_HZ));
    end

    state_t              r_state;
    logic [NOTE_W-1:0]   r_note_q;
    logic [VOL_W-1:0]    r_vol;
    logic [31:0]         r_gap_cnt;
    logic                r_active;

    logic                w_tick;
    logic                w_valid;
    logic                w_tie;
    logic                w_enter_play;
    logic [VOL_W-1:0]    w_vol_eff;
    logic [PERIOD_W-1:0] w_period;
    logic [PERIOD_W-1:0] w_high_len;
    logic                w_audio;

    assign w_tick  = en & beat_tick;
    assign w_valid = (w_ptab[note] != '0);
    // Same note without strike while sounding is a tie: keep the phase.
    assign w_tie   = w_tick & w_valid & ~strike
                   & (note == r_note_q)
                   & ((r_state == PLAY) | (r_state == GAP));

    assign w_enter_play = en & (
        (w_tick & w_valid & ~w_tie & (GAP_CYC == 0))
      | (~w_tick & (r_state == GAP) & (r_gap_cnt == '0)));

    assign w_period   = w_ptab[r_note_q];
    assign w_high_len = (w_period >> 4) * PERIOD_W'(w_vol_eff);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_note_q  <= '0;
            r_vol     <= '0;
            r_gap_cnt <= '0;
            r_active  <= 1'b0;
        end else if (!en) begin
            r_state   <= IDLE;
            r_note_q  <= '0;
            r_gap_cnt <= '0;
            r_active  <= 1'b0;
        end else if (beat_tick) begin
            r_note_q <= note;
            r_vol    <= volume;
            if (!w_valid) begin
                r_state  <= REST;
                r_active <= 1'b0;
            end else if (w_tie) begin
                r_active <= (r_state == PLAY) && (volume != '0);
            end else if (GAP_CYC == 0) begin
                r_state  <= PLAY;
                r_active <= (volume != '0);
            end else begin
                r_state   <= GAP;
                r_gap_cnt <= 32'(GAP_CYC - 1);
                r_active  <= 1'b0;
            end
        end else if (r_state == GAP) begin
            if (r_gap_cnt == '0) begin
                r_state  <= PLAY;
                r_active <= (w_vol_eff != '0);
            end else begin
                r_gap_cnt <= r_gap_cnt - 32'd1;
            end
        end
    end

`ifdef TONE_GEN_FADE_EN
    logic [VOL_W-1:0] r_vol_eff;
    logic [31:0]      r_fade_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vol_eff  <= '0;
            r_fade_cnt <= '0;
        end else if (w_tick && w_valid) begin
            r_vol_eff <= volume;
            if (!w_tie)
                r_fade_cnt <= '0;
        end else if (w_enter_play) begin
            r_fade_cnt <= '0;
        end else if (en && r_state == PLAY) begin
            if (r_fade_cnt == 32'(FADE_CYC - 1)) begin
                r_fade_cnt <= '0;
                if (r_vol_eff > VOL_W'(1))
                    r_vol_eff <= r_vol_eff - VOL_W'(1);
            end else begin
                r_fade_cnt <= r_fade_cnt + 32'd1;
            end
        end
    end

    assign w_vol_eff = r_vol_eff;
`else
    assign w_vol_eff = r_vol;
`endif

    tone_pwm_core u_pwm (
        .clk       (clk),
        .reset     (reset),
        .i_period  (w_period),
        .i_high_len(w_high_len),
        .i_run     (r_state == PLAY),
        .i_clear   (~en | (w_tick & ~w_tie)),
        .o_audio   (w_audio)
    );

    assign audio_out = w_audio;
    assign active    = r_active;
    assign note_q    = r_note_q;

endmodule

// File: tb/tb_tone_gen.sv
// Directed bench for tone_gen at 1 MHz with a 100-cycle gap.
// Build with TONE_GEN_FADE_EN to add the fade-out sequence.
module tb_tone_gen;

    logic       clk;
    logic       reset;
    logic       en;
    logic       beat_tick;
    logic [5:0] note;
    logic       strike;
    logic [2:0] volume;
    logic       audio_out;
    logic       active;
    logic [5:0] note_q;

    int n_chk = 0;
    int n_err = 0;

    tone_gen #(
        .CLK_HZ (1_000_000),
        .NOTE_W (6),
        .VOL_W  (3),
`ifdef TONE_GEN_FADE_EN
        .GAP_CYC(100),
        .FADE_CYC(3000)
`else
        .GAP_CYC(100)
`endif
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .beat_tick(beat_tick),
        .note     (note),
        .strike   (strike),
        .volume   (volume),
        .audio_out(audio_out),
        .active   (active),
        .note_q   (note_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic do_tick(input int n, input bit s, input int v);
        @(negedge clk);
        beat_tick = 1'b1;
        note      = 6'(n);
        strike    = s;
        volume    = 3'(v);
        @(negedge clk);
        beat_tick = 1'b0;
        strike    = 1'b0;
    endtask

    task automatic wait_active(output int k);
        k = 0;
        while (!active && k < 5000) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic wait_rise();
        int k = 0;
        while (!audio_out && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check("rise", 32'(audio_out), 1);
    endtask

    task automatic measure(output int hi, output int lo);
        hi = 0;
        lo = 0;
        while (audio_out && hi < 5000) begin
            @(negedge clk);
            hi++;
        end
        while (!audio_out && lo < 5000) begin
            @(negedge clk);
            lo++;
        end
    endtask

    initial begin
        int     k, hi, lo, nh;
        longint t0, tf, t1;
        reset     = 1'b1;
        en        = 1'b0;
        beat_tick = 1'b0;
        note      = '0;
        strike    = 1'b0;
        volume    = '0;
        #23;
        check("rst_audio", 32'(audio_out), 0);
        check("rst_active", 32'(active), 0);
        check("rst_noteq", 32'(note_q), 0);
        @(negedge clk);
        reset = 1'b0;
        en    = 1'b1;

        // strike from idle: gap, then vol 4 waveform
        do_tick(22, 1, 4);
        check("noteq_22", 32'(note_q), 22);
        check("gap_audio", 32'(audio_out), 0);
        wait_active(k);
        check("gap_len", k, 100);
        check("audio_lag", 32'(audio_out), 0);
        @(negedge clk);
        check("audio_rise", 32'(audio_out), 1);
        measure(hi, lo);
        check("v4_hi", hi, 568);
        check("v4_lo", lo, 1704);
        measure(hi, lo);
        check("v4_hi2", hi, 568);
        check("v4_lo2", lo, 1704);

        // tie to vol 7 mid-period: no phase reset, new duty next period
        t0 = $time;
        do_tick(22, 0, 7);
        check("tie_active", 32'(active), 1);
        k = 0;
        while (audio_out && k < 5000) begin
            @(negedge clk);
            k++;
        end
        tf = $time;
        k = 0;
        while (!audio_out && k < 5000) begin
            @(negedge clk);
            k++;
        end
        t1 = $time;
        check("tie_cur_hi", 32'((tf - t0) / 10), 568);
        check("tie_period", 32'((t1 - t0) / 10), 2272);
        measure(hi, lo);
        check("v7_hi", hi, 994);
        check("v7_lo", lo, 1278);

        // re-strike in PLAY, then restart the gap halfway through
        do_tick(22, 1, 7);
        check("rs_audio", 32'(audio_out), 0);
        check("rs_active", 32'(active), 0);
        repeat (50) @(negedge clk);
        do_tick(22, 1, 7);
        wait_active(k);
        check("regap_len", k, 100);
        @(negedge clk);
        measure(hi, lo);
        check("rs_hi", hi, 994);
        check("rs_lo", lo, 1278);

        // rests: index 0 and out of range
        do_tick(0, 0, 4);
        check("rest0_active", 32'(active), 0);
        check("rest0_noteq", 32'(note_q), 0);
        repeat (3) @(negedge clk);
        check("rest0_audio", 32'(audio_out), 0);
        do_tick(55, 1, 4);
        check("rest55_noteq", 32'(note_q), 55);
        repeat (300) @(negedge clk);
        check("rest55_active", 32'(active), 0);
        check("rest55_audio", 32'(audio_out), 0);
        do_tick(22, 0, 4);
        wait_active(k);
        check("rest_gap_len", k, 100);

        // en drop with a simultaneous tick during GAP
        do_tick(22, 1, 4);
        repeat (10) @(negedge clk);
        en        = 1'b0;
        beat_tick = 1'b1;
        note      = 6'd5;
        strike    = 1'b1;
        volume    = 3'd7;
        @(negedge clk);
        beat_tick = 1'b0;
        strike    = 1'b0;
        check("en_noteq", 32'(note_q), 0);
        check("en_active", 32'(active), 0);
        check("en_audio", 32'(audio_out), 0);
        repeat (150) @(negedge clk);
        check("en_hold_active", 32'(active), 0);
        en = 1'b1;
        repeat (5) @(negedge clk);
        check("en_idle_active", 32'(active), 0);
        check("en_idle_audio", 32'(audio_out), 0);

        // volume 0: plays silently, not active
        do_tick(22, 1, 0);
        nh = 0;
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            if (audio_out) nh++;
        end
        check("v0_highs", nh, 0);
        check("v0_active", 32'(active), 0);

        // asynchronous reset in the middle of PLAY
        do_tick(22, 1, 4);
        wait_active(k);
        wait_rise();
        repeat (10) @(negedge clk);
        check("pre_rst_audio", 32'(audio_out), 1);
        #2 reset = 1'b1;
        #1;
        check("arst_audio", 32'(audio_out), 0);
        check("arst_active", 32'(active), 0);
        check("arst_noteq", 32'(note_q), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("post_rst_active", 32'(active), 0);
        check("post_rst_audio", 32'(audio_out), 0);

`ifdef TONE_GEN_FADE_EN
        do_tick(22, 1, 3);
        wait_active(k);
        wait_rise();
        measure(hi, lo);
        check("fade_hi0", hi, 426);
        measure(hi, lo);
        check("fade_hi1", hi, 426);
        measure(hi, lo);
        check("fade_hi2", hi, 284);
        measure(hi, lo);
        check("fade_hi3", hi, 142);
        measure(hi, lo);
        check("fade_hi4", hi, 142);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
